spart_tx_queue: RTL and testbench
=================================

Name: spart_tx_queue

Overview:
Transmit side of the SPART. It buffers bytes written by the MEM stage and serializes them onto the UART TX line as 8N1 frames. It produces the `full` signal the pipeline stall control uses to freeze PC/IFID/IDEX while letting EXMEM/MEMWB drain. It consumes the `send` strobe and the store data from the MEM stage.

Parameters:
DEPTH, 8, FIFO entries; power of two, at least 2
DATA_W, 8, bits per entry and per frame
BAUD_DIV, 434, clock cycles per bit period; at least 2 (434 gives 115200 baud at 50 MHz)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
send  input  1  MEM-stage write strobe for the SPART TX register
tx_data  input  DATA_W  byte to enqueue; sampled when `send` is accepted
full  output  1  queue holds DEPTH entries; feeds stall control
empty  output  1  queue holds 0 entries
count  output  $clog2(DEPTH)+1  current occupancy
busy  output  1  serializer is not in IDLE
txd  output  1  serial line; idles high

Behaviour:
- Clocking and reset: single clock. Reset is asynchronous and active-low. All state clears immediately on rst_n low.
- Reset values: count=0, full=0, empty=1, busy=0, txd=1, pointers=0, FSM=IDLE.
- Reset mid-frame: the frame is aborted, txd returns high at once, and queued data is discarded.
- Flags: full = (count==DEPTH) and empty = (count==0). Both are decoded from registered count, so they are glitch-free and valid from the cycle after the change.
- Enqueue: on a rising edge with send=1 and full=0, write tx_data at wr_ptr and increment wr_ptr modulo DEPTH.
- Enqueue while full: send=1 with full=1 is ignored; no write, no pointer or count change. The stall control guarantees the pipeline holds and re-presents the store, so no data is lost at system level.
- Dequeue: the FSM pops only in IDLE when empty=0. On that edge it loads the shift register from the head entry and increments rd_ptr modulo DEPTH.
- Count update: push only gives +1; pop only gives −1; push and pop in the same cycle leave count unchanged.
- Push and pop together while full=1: the pop happens and the push is dropped, because full is evaluated from pre-edge count. full deasserts the next cycle.
- Pointer wrap: DEPTH is a power of two, so pointers wrap naturally.
- Serializer FSM states: IDLE, START, DATA, STOP. A baud counter counts 0..BAUD_DIV−1 and a bit index counts 0..DATA_W−1.
- IDLE: txd=1, busy=0. If empty=0, pop, clear the baud counter, and go to START.
- START: txd=0 for BAUD_DIV cycles, then go to DATA with bit index 0.
- DATA: txd=shift[0], LSB first. Each bit is held BAUD_DIV cycles, then the register shifts right. After bit DATA_W−1 completes, go to STOP.
- STOP: txd=1 for BAUD_DIV cycles, then go to IDLE.
- busy=1 in START, DATA and STOP.
- txd is driven from a register, so there is no combinational path from the FSM to the pin.
- Frame timing: one frame lasts (DATA_W+2)·BAUD_DIV cycles. Back-to-back frames are separated by exactly one IDLE cycle with txd=1.
- Latency: with the queue empty and the FSM in IDLE, send accepted at edge N makes empty=0 after N. The pop occurs at N+1 and txd falls after edge N+1.
- tx_data is captured at enqueue. Later changes to tx_data do not affect queued bytes.

Test Plan:
1. Single frame: BAUD_DIV=4, send 0xA5 once → txd low 4 cycles, then bits 1,0,1,0,0,1,0,1 at 4 cycles each, then high 4 cycles. busy is high for exactly 40 cycles; empty returns to 1 the cycle after the pop.
2. Fill to full: BAUD_DIV=4, DEPTH=8, send 9 bytes 0x01..0x09 on consecutive cycles from reset. The first is popped at the second edge, so 0x01..0x09 all enter. full asserts when count reaches 8. A further send while full is dropped and count stays 8.
3. Drop check: hold send=1 with 0xFF while full=1 for 20 cycles → no entry added. The output byte sequence contains no extra 0xFF frames.
4. Simultaneous push/pop at full: full=1 and the FSM pops on the same edge as send=1 → the write is dropped, count becomes 7, and full=0 the next cycle.
5. Back-to-back: queue 0x00 and 0xFF → the two frames are separated by exactly one cycle of txd=1 between the STOP of the first and the START of the second.
6. Reset mid-frame: drop rst_n during DATA bit 3 → txd=1, busy=0, empty=1, count=0 immediately (asynchronous). After release, no residual frame is transmitted.

Source files
------------

// File: rtl/spart_tx_queue.sv
// SPART transmit queue: DEPTH-entry byte FIFO feeding an 8N1 serializer. A send is accepted when not full and a send while full is dropped.
// The first byte pops one cycle after enqueue and txd falls on that edge. full/empty/count are decoded from registered state.
module spart_tx_queue #(
  parameter int DEPTH    = 8,
  parameter int DATA_W   = 8,
  parameter int BAUD_DIV = 434
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       send,
  input  logic [DATA_W-1:0]          tx_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       busy,
  output logic                       txd
);
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(BAUD_DIV);
  localparam int BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic                txd_q, txd_d;
  logic                push, pop;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign busy  = (state_q != IDLE);
  assign txd   = txd_q;

  // full is evaluated from pre-edge count, so a push coinciding with a pop at full is dropped
  assign push = send && !full;
  assign pop  = (state_q == IDLE) && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_d = START;
          baud_d  = '0;
          shift_d = mem_q[rd_ptr_q];
        end
      end
      START: begin
        if (baud_q == BAUD_LAST) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) state_d = STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_q == BAUD_LAST) begin
          state_d = IDLE;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Line level follows the next state so the pin is a pure flop output
    txd_d = 1'b1;
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= tx_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
    end
  end
endmodule

// File: tb/tb_spart_tx_queue.sv
// Bench for spart_tx_queue: a line decoder rebuilds each 8N1 frame and checks it against a queue of accepted bytes.
module tb_spart_tx_queue;
  localparam int DEPTH  = 8;
  localparam int DATA_W = 8;
  localparam int BAUD   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        send = 1'b0;
  logic [7:0]  tx_data = '0;
  logic        full, empty, busy, txd;
  logic [3:0]  count;

  int          n_tests = 0;
  int          n_fail = 0;
  logic [7:0]  sb [$];
  int          frames_rx = 0;
  bit          in_frame = 1'b0;
  int          fcyc = 0;
  logic [7:0]  rx_sh = '0;

  spart_tx_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .BAUD_DIV(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .send(send), .tx_data(tx_data),
    .full(full), .empty(empty), .count(count), .busy(busy), .txd(txd)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Line decoder: samples mid-bit, compares each completed frame with the scoreboard
  always @(posedge clk) begin
    int k;
    logic [7:0] exp_b;
    #2;
    if (!rst_n) begin
      in_frame = 1'b0;
    end else begin
      if (!in_frame) begin
        if (txd == 1'b0) begin
          in_frame = 1'b1;
          fcyc = 0;
        end
      end else begin
        fcyc++;
      end
      if (in_frame && (fcyc % BAUD == BAUD / 2)) begin
        k = fcyc / BAUD;
        if (k == 0) begin
          check_eq("start_bit", 32'(txd), 32'd0);
        end else if (k <= DATA_W) begin
          rx_sh[k-1] = txd;
        end else begin
          check_eq("stop_bit", 32'(txd), 32'd1);
          frames_rx++;
          check_eq("sb_has_entry", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp_b = sb.pop_front();
            check_eq("rx_byte", 32'(rx_sh), 32'(exp_b));
          end
          in_frame = 1'b0;
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((!empty || busy) && n < 1000) begin
      tick();
      n++;
    end
    check_eq(tag, 32'(n < 1000), 32'd1);
    repeat (3) tick();
  endtask

  initial begin
    int n, gap, lows, frames_before;

    // Reset values
    rst_n = 1'b0;
    tick(); tick();
    check_eq("rst_count", 32'(count), 32'd0);
    check_eq("rst_full",  32'(full),  32'd0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_busy",  32'(busy),  32'd0);
    check_eq("rst_txd",   32'(txd),   32'd1);
    rst_n = 1'b1;
    tick();

    // Single frame, enqueue/pop latency and busy width
    send = 1'b1; tx_data = 8'hA5; sb.push_back(8'hA5);
    tick();
    send = 1'b0; tx_data = 8'h00;
    check_eq("t1_empty_after_push", 32'(empty), 32'd0);
    check_eq("t1_count_after_push", 32'(count), 32'd1);
    check_eq("t1_txd_before_pop",   32'(txd),   32'd1);
    tick();
    check_eq("t1_busy_after_pop",  32'(busy),  32'd1);
    check_eq("t1_txd_start",       32'(txd),   32'd0);
    check_eq("t1_empty_after_pop", 32'(empty), 32'd1);
    n = 1;
    while (n < 100) begin
      tick();
      if (!busy) break;
      n++;
    end
    check_eq("t1_busy_cycles", 32'(n), 32'd40);
    repeat (3) tick();
    check_eq("t1_frames", 32'(frames_rx), 32'd1);

    // Fill to full from reset, then hold send while full
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 1; i <= 9; i++) begin
      send = 1'b1; tx_data = 8'(i); sb.push_back(8'(i));
      tick();
    end
    check_eq("t2_count_full", 32'(count), 32'd8);
    check_eq("t2_full",       32'(full),  32'd1);
    tx_data = 8'hFF;
    for (int e = 10; e <= 42; e++) begin
      tick();
      check_eq("t3_drop_count", 32'(count), 32'd8);
      check_eq("t3_drop_full",  32'(full),  32'd1);
    end
    // Edge 43: the FSM pops while send is still high at full
    tick();
    send = 1'b0;
    check_eq("t4_count_after_pop", 32'(count), 32'd7);
    check_eq("t4_full_clear",      32'(full),  32'd0);
    drain("t2_drain_timeout");
    check_eq("t2_frames", 32'(frames_rx), 32'd10);
    check_eq("t2_sb_empty", 32'(sb.size()), 32'd0);

    // Back-to-back frames: exactly one idle cycle between them
    send = 1'b1; tx_data = 8'h00; sb.push_back(8'h00);
    tick();
    tx_data = 8'hFF; sb.push_back(8'hFF);
    tick();
    send = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      tick();
      n++;
    end
    check_eq("t5_first_end", 32'(n < 100), 32'd1);
    gap = 0;
    while (!busy && gap < 10) begin
      check_eq("t5_gap_txd", 32'(txd), 32'd1);
      gap++;
      tick();
    end
    check_eq("t5_gap_cycles", 32'(gap), 32'd1);
    check_eq("t5_second_start", 32'(txd), 32'd0);
    drain("t5_drain_timeout");
    check_eq("t5_frames", 32'(frames_rx), 32'd12);

    // Reset during DATA bit 3 with another byte still queued
    send = 1'b1; tx_data = 8'h3C; sb.push_back(8'h3C);
    tick();
    tx_data = 8'h5A; sb.push_back(8'h5A);
    tick();
    send = 1'b0;
    repeat (17) tick();
    check_eq("t6_busy_before", 32'(busy), 32'd1);
    check_eq("t6_count_before", 32'(count), 32'd1);
    frames_before = frames_rx;
    rst_n = 1'b0;
    #1;
    check_eq("t6_txd",   32'(txd),   32'd1);
    check_eq("t6_busy",  32'(busy),  32'd0);
    check_eq("t6_empty", 32'(empty), 32'd1);
    check_eq("t6_count", 32'(count), 32'd0);
    sb.delete();
    tick(); tick();
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (!txd || busy) lows++;
    end
    check_eq("t6_no_residual", 32'(lows), 32'd0);
    check_eq("t6_frames", 32'(frames_rx), 32'(frames_before));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
